// File: rtl/ethernet_pkg.sv
// Shared constants, register map defaults and FSM state type for the Ethernet TX path.
package ethernet_pkg;

  localparam int unsigned eth_mtu           = 2048;
  localparam int unsigned packet_size_width = 12;
  localparam int unsigned mmio_addr_width   = 14;
  localparam int unsigned size_width        = 2;
  localparam int unsigned poll_limit        = 1024;

  localparam logic [mmio_addr_width-1:0] tx_buf_base_default  = 14'h0800;
  localparam logic [mmio_addr_width-1:0] tx_req_addr_default  = 14'h1010;
  localparam logic [mmio_addr_width-1:0] tx_send_addr_default = 14'h1018;
  localparam logic [mmio_addr_width-1:0] tx_size_addr_default = 14'h1028;

  typedef enum logic [2:0] {
    IDLE, POLL_REQ, POLL_WAIT, WRITE, SIZE, SEND, DONE
  } state_e;

  // op_size encoding is log2 of the access size in bytes
  function automatic logic [size_width-1:0] full_word_size(input int unsigned width);
    return size_width'($clog2(width / 8));
  endfunction

endpackage

// File: rtl/ethernet_tx_poll_timer.sv
// Counts consecutive "buffer busy" poll responses; flags the one that reaches the limit.
module ethernet_tx_poll_timer
  import ethernet_pkg::*;
#(
  parameter int unsigned limit_p = poll_limit
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic zero_i,
  output logic expired_o
);

  localparam int unsigned cw_lp = $clog2(limit_p);

  logic [cw_lp-1:0] count;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      count <= '0;
    end else if (zero_i) begin
      count <= count + cw_lp'(1);
    end
  end

  assign expired_o = zero_i && (count == cw_lp'(limit_p - 1));

endmodule

// File: rtl/ethernet_tx_mmio_initiator.sv
// Copies one packet from a payload stream into the MAC TX buffer over MMIO, then triggers send.
// Optional poll timeout is enabled by defining ETH_TX_INIT_TIMEOUT_EN.
module ethernet_tx_mmio_initiator
  import ethernet_pkg::*;
#(
  parameter int unsigned                 data_width_p   = 32,
  parameter logic [mmio_addr_width-1:0]  tx_buf_base_p  = tx_buf_base_default,
  parameter logic [mmio_addr_width-1:0]  tx_req_addr_p  = tx_req_addr_default,
  parameter logic [mmio_addr_width-1:0]  tx_send_addr_p = tx_send_addr_default,
  parameter logic [mmio_addr_width-1:0]  tx_size_addr_p = tx_size_addr_default
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cmd_v_i,
  input  logic [packet_size_width-1:0]  cmd_len_i,
  output logic                          cmd_ready_o,
  input  logic                          data_v_i,
  input  logic [data_width_p-1:0]       data_i,
  output logic                          data_yumi_o,
  output logic [mmio_addr_width-1:0]    addr_o,
  output logic                          write_en_o,
  output logic                          read_en_o,
  output logic [size_width-1:0]         op_size_o,
  output logic [data_width_p-1:0]       write_data_o,
  input  logic [data_width_p-1:0]       read_data_i,
  input  logic                          read_data_v_i,
  output logic                          done_o,
  output logic                          error_o,
  output logic                          busy_o
);

  localparam int unsigned           shift_lp   = $clog2(data_width_p / 8);
  localparam int unsigned           lw_lp      = packet_size_width + 1;
  localparam logic [size_width-1:0] op_full_lp = full_word_size(data_width_p);

  state_e                       state, state_n;
  logic [packet_size_width-1:0] len_r;
  logic [packet_size_width-1:0] beat_r;
  logic                         err_r;
  logic                         accept, len_ok, beat_last, timeout;
  logic [lw_lp-1:0]             beats_total;
  logic                         unused_read_bits;

  // accept is built from state rather than cmd_ready_o to keep the comb block loop-free
  assign accept      = cmd_v_i && reset_n_i && (state == IDLE);
  assign len_ok      = (cmd_len_i != '0) && (cmd_len_i <= packet_size_width'(eth_mtu));
  assign beats_total = (lw_lp'(len_r) + lw_lp'((data_width_p / 8) - 1)) >> shift_lp;
  assign beat_last   = ({1'b0, beat_r} == beats_total - lw_lp'(1));
  assign busy_o      = (state != IDLE);
  assign unused_read_bits = ^read_data_i[data_width_p-1:1];

`ifdef ETH_TX_INIT_TIMEOUT_EN
  logic poll_zero;
  assign poll_zero = (state == POLL_WAIT) && read_data_v_i && !read_data_i[0];

  ethernet_tx_poll_timer #(.limit_p(poll_limit)) u_poll_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (accept),
    .zero_i    (poll_zero),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      len_r  <= '0;
      beat_r <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        len_r  <= cmd_len_i;
        beat_r <= '0;
        err_r  <= !len_ok;
      end else if (state == WRITE && data_v_i) begin
        beat_r <= beat_r + packet_size_width'(1);
      end else if (state == POLL_WAIT && read_data_v_i && !read_data_i[0] && timeout) begin
        err_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    cmd_ready_o  = 1'b0;
    data_yumi_o  = 1'b0;
    addr_o       = '0;
    write_en_o   = 1'b0;
    read_en_o    = 1'b0;
    op_size_o    = '0;
    write_data_o = '0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = reset_n_i;
        if (accept) state_n = len_ok ? POLL_REQ : DONE;
      end
      POLL_REQ: begin
        read_en_o = 1'b1;
        addr_o    = tx_req_addr_p;
        op_size_o = op_full_lp;
        state_n   = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (read_data_v_i) begin
          if (read_data_i[0])  state_n = WRITE;
          else if (timeout)    state_n = DONE;
          else                 state_n = POLL_REQ;
        end
      end
      WRITE: begin
        data_yumi_o = data_v_i;
        if (data_v_i) begin
          write_en_o   = 1'b1;
          addr_o       = tx_buf_base_p + (mmio_addr_width'(beat_r) << shift_lp);
          write_data_o = data_i;
          op_size_o    = op_full_lp;
          if (beat_last) state_n = SIZE;
        end
      end
      SIZE: begin
        write_en_o   = 1'b1;
        addr_o       = tx_size_addr_p;
        write_data_o = data_width_p'(len_r);
        op_size_o    = op_full_lp;
        state_n      = SEND;
      end
      SEND: begin
        write_en_o   = 1'b1;
        addr_o       = tx_send_addr_p;
        write_data_o = data_width_p'(1);
        op_size_o    = op_full_lp;
        state_n      = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        error_o = err_r;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ethernet_tx_mmio_initiator.sv
// Randomized directed bench: each command's MMIO trace is compared against a list built from the packet rules.
module tb_ethernet_tx_mmio_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_v;
  logic [11:0] cmd_len;
  logic        cmd_ready;
  logic        data_v;
  logic [31:0] data;
  logic        data_yumi;
  logic [13:0] addr;
  logic        write_en;
  logic        read_en;
  logic [1:0]  op_size;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_v;
  logic        done;
  logic        error;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef ETH_TX_INIT_TIMEOUT_EN
  localparam bit timeout_en = 1'b1;
`else
  localparam bit timeout_en = 1'b0;
`endif

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wrs[$];
  logic [31:0] payload[$];

  always #5 clk = ~clk;

  ethernet_tx_mmio_initiator #(
    .data_width_p   (32),
    .tx_buf_base_p  (14'h0800),
    .tx_req_addr_p  (14'h1010),
    .tx_send_addr_p (14'h1018),
    .tx_size_addr_p (14'h1028)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .cmd_v_i       (cmd_v),
    .cmd_len_i     (cmd_len),
    .cmd_ready_o   (cmd_ready),
    .data_v_i      (data_v),
    .data_i        (data),
    .data_yumi_o   (data_yumi),
    .addr_o        (addr),
    .write_en_o    (write_en),
    .read_en_o     (read_en),
    .op_size_o     (op_size),
    .write_data_o  (write_data),
    .read_data_i   (read_data),
    .read_data_v_i (read_data_v),
    .done_o        (done),
    .error_o       (error),
    .busy_o        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end-to-end; nzero = number of "busy" poll answers before "free".
  task automatic run_cmd(input int len, input int nzero, input bit toggle, input int rst_beat);
    int  beats, idx, reads, reads_before_wr, cycles;
    bit  valid, timed_out, done_seen, err_seen, aborted, viol, resp_pending;
    valid     = (len >= 1) && (len <= 2048);
    timed_out = timeout_en && valid && (nzero >= 1024);
    beats     = valid ? (len + 3) / 4 : 0;
    wrs.delete();
    payload.delete();
    for (int i = 0; i <= beats; i++) payload.push_back($urandom());
    idx = 0; reads = 0; reads_before_wr = -1; cycles = 0;
    done_seen = 0; err_seen = 0; aborted = 0; viol = 0; resp_pending = 0;

    @(negedge clk);
    #1 check("cmd_ready_idle", cmd_ready, 1);
    cmd_v   = 1'b1;
    cmd_len = 12'(len);
    @(posedge clk);
    #1;
    cmd_v   = 1'b0;
    cmd_len = '0;

    while (!done_seen && !aborted && cycles < 6000) begin
      @(negedge clk);
      cycles++;
      read_data_v  = resp_pending;
      read_data    = (reads > nzero) ? ($urandom() | 32'h1) : ($urandom() & 32'hFFFF_FFFE);
      resp_pending = 0;
      data_v       = toggle ? cycles[0] : 1'b1;
      data         = (idx < payload.size()) ? payload[idx] : 32'h0;
      #1;
      if (write_en && read_en) viol = 1;
      if (!busy) viol = 1;
      if (data_yumi && !write_en) viol = 1;
      if (reads_before_wr >= 0 && idx < beats && write_en !== data_v) viol = 1;
      if (read_en) begin
        if (addr !== 14'h1010 || op_size !== 2'd2) viol = 1;
        reads++;
        resp_pending = 1;
      end
      if (write_en) begin
        if (op_size !== 2'd2) viol = 1;
        if (data_yumi) begin
          if (reads_before_wr < 0) reads_before_wr = reads;
          if (rst_beat >= 0 && idx == rst_beat) begin
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            check("rst_write_en", write_en, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            reset_n = 1'b1;
            aborted = 1;
          end
          idx++;
        end
        wrs.push_back('{a: addr, d: write_data});
      end
      if (done) begin
        done_seen = 1;
        err_seen  = error;
      end
    end
    read_data_v = 1'b0;
    data_v      = 1'b0;

    if (cycles >= 6000) check("cycle_budget", 0, 1);

    if (aborted) begin
      // a late status response must not revive the abandoned command
      @(negedge clk);
      read_data_v = 1'b1;
      read_data   = 32'h1;
      @(negedge clk);
      read_data_v = 1'b0;
      #1;
      check("post_rst_busy", busy, 0);
      check("post_rst_mmio", {write_en, read_en, done}, 0);
    end else begin
      check("protocol", viol, 0);
      check("done", done_seen, 1);
      if (!valid) begin
        check("rej_error", err_seen, 1);
        check("rej_reads", reads, 0);
        check("rej_writes", wrs.size(), 0);
        check("rej_latency_le2", cycles <= 2, 1);
      end else if (timed_out) begin
        check("to_error", err_seen, 1);
        check("to_reads", reads, 1024);
        check("to_writes", wrs.size(), 0);
      end else begin
        check("error", err_seen, 0);
        check("reads", reads, nzero + 1);
        check("reads_before_wr", reads_before_wr, nzero + 1);
        check("write_count", wrs.size(), beats + 2);
        for (int k = 0; k < beats && k < wrs.size(); k++) begin
          check("buf_addr", wrs[k].a, 14'h0800 + 14'(4 * k));
          check("buf_data", wrs[k].d, payload[k]);
        end
        if (wrs.size() == beats + 2) begin
          check("size_addr", wrs[beats].a, 14'h1028);
          check("size_data", wrs[beats].d, 32'(len));
          check("send_addr", wrs[beats+1].a, 14'h1018);
          check("send_data", wrs[beats+1].d, 32'h1);
        end
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    cmd_v       = 1'b0;
    cmd_len     = '0;
    data_v      = 1'b0;
    data        = '0;
    read_data   = '0;
    read_data_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_outputs", {cmd_ready, data_yumi, write_en, read_en, done, error}, 0);
    check("reset_bus", {addr, op_size, write_data}, 0);
    reset_n = 1'b1;
    #1 check("cmd_ready_release", cmd_ready, 1);

    run_cmd(60, 0, 0, -1);
    run_cmd(61, 0, 0, -1);
    run_cmd(60, 3, 0, -1);
    run_cmd(0, 0, 0, -1);
    run_cmd(2049, 0, 0, -1);
    run_cmd(int'($urandom_range(2050, 4095)), 0, 0, -1);
    run_cmd(100, 1, 1, -1);
    run_cmd(2048, 2, 1, -1);
    run_cmd(1, 0, 0, -1);
    run_cmd(200, 0, 0, 5);
    run_cmd(64, 0, 0, -1);
    for (int n = 0; n < 4; n++)
      run_cmd(int'($urandom_range(1, 2048)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    if (timeout_en) begin
      run_cmd(8, 1024, 0, -1);
      run_cmd(16, 2, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_mmio_initiator.md
ETHERNET_TX_MMIO_INITIATOR -- requirements
Module: ethernet_tx_mmio_initiator

Interface
REQ-001 SHALL have parameter data_width_p, default 32, MMIO data width in bits (32 or 64).
REQ-002 SHALL have parameter tx_buf_base_p, default 14'h0800, byte address of TX packet buffer word 0.
REQ-003 SHALL have parameter tx_req_addr_p, default 14'h1010, byte address of TX-ready status register (bit0 = buffer free).
REQ-004 SHALL have parameter tx_send_addr_p, default 14'h1018, byte address of send-trigger register.
REQ-005 SHALL have parameter tx_size_addr_p, default 14'h1028, byte address of TX packet-size register.
REQ-006 SHALL have ports clk_i input 1 (sole clock) and reset_n_i input 1 (synchronous, active-low reset).
REQ-007 SHALL have ports cmd_v_i input 1, cmd_len_i input 12, cmd_ready_o output 1: packet command in bytes, valid/ready.
REQ-008 SHALL have ports data_v_i input 1, data_i input data_width_p, data_yumi_o output 1: payload stream, little-endian, byte 0 in bits [7:0].
REQ-009 SHALL have ports addr_o output 14, write_en_o output 1, read_en_o output 1, op_size_o output size_width, write_data_o output data_width_p: MMIO request to controller.
REQ-010 SHALL have ports read_data_i input data_width_p and read_data_v_i input 1: MMIO sync-read response.
REQ-011 SHALL have ports done_o output 1 (one-cycle completion pulse), error_o output 1 (qualified by done_o), busy_o output 1.

Function
REQ-012 SHALL implement states IDLE, POLL_REQ, POLL_WAIT, WRITE, SIZE, SEND, DONE.
REQ-013 IDLE: cmd_ready_o=1; cmd_v_i&cmd_ready_o captures cmd_len_i; valid length (1..2048) -> POLL_REQ, else -> DONE with error.
REQ-014 POLL_REQ: read_en_o=1, addr_o=tx_req_addr_p, op_size_o=full word for exactly one cycle -> POLL_WAIT.
REQ-015 POLL_WAIT: on read_data_v_i, bit0=1 -> WRITE, bit0=0 -> POLL_REQ; no new request issued while waiting.
REQ-016 WRITE: data_yumi_o=data_v_i; each consumed beat SHALL drive write_en_o=1, addr_o=tx_buf_base_p+k*(data_width_p/8), write_data_o=data_i the same cycle, k=0,1,...
REQ-017 Beat count SHALL be ceil(len/(data_width_p/8)); last beat written as full word (tail bytes don't-care); after last beat -> SIZE.
REQ-018 SIZE: one write, addr_o=tx_size_addr_p, write_data_o=zero-extended len, full-word op_size -> SEND.
REQ-019 SEND: one write, addr_o=tx_send_addr_p, write_data_o=1 -> DONE.
REQ-020 DONE: done_o=1 one cycle, error_o=1 only on rejected length or timeout -> IDLE.
REQ-021 write_en_o and read_en_o SHALL never assert together; both deasserted in IDLE, POLL_WAIT, DONE, and WRITE without data_v_i.
REQ-022 busy_o SHALL equal (state != IDLE); data_yumi_o SHALL be 0 outside WRITE.
REQ-023 Byte-address arithmetic SHALL be 14-bit with no wrap; lengths up to 2048 never exceed tx_buf_base_p+2047.

Reset
REQ-024 reset_n_i=0 at a clk_i edge SHALL force IDLE; all outputs 0 except cmd_ready_o (1 after reset release), counters cleared.
REQ-025 Reset mid-operation SHALL abandon the command without done_o; a POLL_WAIT response arriving after reset SHALL be ignored.

Configuration
REQ-026 With ETH_TX_INIT_TIMEOUT_EN defined, a poll counter SHALL abort to DONE with error_o=1 after 1024 consecutive bit0=0 responses; without it, polling SHALL continue indefinitely and error_o rises only for rejected lengths.

Structure
REQ-027 Shared package ethernet_pkg SHALL hold eth_mtu (2048), packet_size width (12), MMIO address width (14), register-offset constants and the state enum.
REQ-028 Poll timeout counter SHALL be sub-module ethernet_tx_poll_timer, instantiated only under ETH_TX_INIT_TIMEOUT_EN.

Verification
REQ-029 len=60, data_width_p=32, status bit0=1 first poll -> 15 writes at 0x0800..0x0838, size write 60 at 0x1028, write 1 at 0x1018, done_o=1, error_o=0.
REQ-030 len=61 -> 16 buffer writes (last at 0x083C), size write value 61.
REQ-031 Status returns bit0=0 three times then 1 -> exactly 4 reads to 0x1010 before first buffer write.
REQ-032 len=0 and len=2049 -> no MMIO activity, done_o=1 and error_o=1 two cycles after accept.
REQ-033 data_v_i toggled 1/0 every cycle -> write_en_o follows data_v_i, addresses contiguous, no beat lost or duplicated.
REQ-034 reset_n_i=0 during WRITE beat 5 -> next cycle write_en_o=0, busy_o=0; new len=64 command then completes normally; with macro, 1024 zero polls -> done_o=1, error_o=1.
